period_setter: RTL and testbench
================================

PERIOD_SETTER -- requirements
Module: period_setter

Interface
REQ-001 The block SHALL have a single clock clk, and reset rst SHALL be synchronous and active-high.
REQ-002 The block SHALL provide these parameters (name, default, meaning):
- DEB_CYCLES, 20'd500000: consecutive stable cycles required to accept a button level.
- REPEAT_DELAY, 27'd25000000: hold cycles after an accepted press before auto-repeat starts.
- REPEAT_RATE, 27'd5000000: cycles between auto-repeat steps.
- MIN_PERIOD, 8'd1: lowest allowed period.
- MAX_PERIOD, 8'd250: highest allowed period.
- INIT_PERIOD, 8'd100: period value after reset.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- btn_up, in, 1: raw active-high button, asynchronous, bouncy; increments period.
- btn_dn, in, 1: raw active-high button, asynchronous, bouncy; decrements period.
- btn_quick, in, 1: raw active-high button; toggles quick.
- period, out, 8: registered tick-period value, feeds the counter/display stage key input.
- quick, out, 1: registered fast-count mode level, feeds the counter/display stage quick input.
- changed, out, 1: one-cycle pulse when period or quick changes.

Function
REQ-004 Each raw button SHALL pass through a two-flop synchronizer before any other use.
REQ-005 Each synchronized button SHALL have its own debounce counter and debounced level:
- Counter increments while the synchronized value differs from the debounced level.
- Counter clears to 0 on any cycle where they match.
- When the counter reaches DEB_CYCLES-1 while still differing, the debounced level takes the synchronized value and the counter clears.
REQ-006 A press event SHALL be a 0->1 transition of a debounced level; releases generate no event.
REQ-007 Latency SHALL be fixed: a raw level held stable from edge N SHALL update period/quick at edge N+2+DEB_CYCLES+1.
REQ-008 An up event SHALL set period to period+1, saturating at MAX_PERIOD; a down event SHALL set period-1, saturating at MIN_PERIOD.
- Arithmetic is 8-bit.
- Saturation SHALL be checked before the add/subtract, so period never wraps 255->0 or 0->255.
REQ-009 If debounced up and down are both high, period SHALL hold, and any up/down event in that cycle SHALL be ignored.
REQ-010 A quick event SHALL invert quick; quick events SHALL be independent of up/down and SHALL be honoured in the same cycle as a period change.
REQ-011 Auto-repeat FSM states and transitions:
- IDLE: on an up or down event (exactly one button held), load the repeat counter and go to HOLD.
- HOLD: after REPEAT_DELAY cycles with the same single button held, apply one step and go to REPEAT.
- REPEAT: apply one step every REPEAT_RATE cycles.
- Any state: release of that button, or both buttons high, returns to IDLE and clears the counter.
REQ-012 Auto-repeat steps SHALL obey the same saturation as REQ-008; at the limit, steps SHALL produce no change and no changed pulse.
REQ-013 changed SHALL be high for exactly the one cycle after any edge at which period or quick takes a new value; otherwise changed SHALL be 0.
REQ-014 All outputs SHALL be registered, with no combinational path from any input.

Reset
REQ-015 While rst is high at a clock edge:
- period = INIT_PERIOD, quick = 0, changed = 0.
- All synchronizer flops, debounced levels and debounce counters = 0.
- FSM = IDLE, repeat counter = 0.
REQ-016 rst SHALL take priority over all events; a button held through reset release SHALL be treated as a fresh press, debounced from zero after reset.

Verification
(Parameters for all scenarios: DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, MIN=1, MAX=9, INIT=5.)
REQ-017 Reset: assert rst for 2 cycles -> period=5, quick=0, changed=0.
REQ-018 Bounce rejection: btn_up toggles every 2 cycles for 30 cycles then stays low -> period stays 5, changed never pulses.
REQ-019 Clean press: btn_up high from edge N -> period=6 and changed=1 at edge N+7; btn_dn press thereafter -> period back to 5.
REQ-020 Saturation: 10 up presses from 5 -> period 9 after 4th, stays 9; changed pulses exactly 4 times. Symmetric test at MIN=1.
REQ-021 Auto-repeat: hold btn_dn from 9 -> step at debounce, next step 20 cycles later, then every 5 cycles until 1; no further changes.
REQ-022 Simultaneous events: up and down held together -> period unchanged. btn_quick pressed during an up step -> period+1 and quick toggles on the same edge, single changed pulse. rst mid-repeat -> FSM IDLE, period=5.

Source files
------------

// File: rtl/period_setter.sv
// Button-driven tick-period selector with synchronizers, debouncers and auto-repeat.
// Outputs a saturating period, a quick-mode toggle and a one-cycle change pulse.

module ps_debounce #(
   parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_level
);

   logic        r_s1;
   logic        r_s2;
   logic        r_lvl;
   logic [19:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_lvl <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_s1 <= i_raw;
         r_s2 <= r_s1;
         if (r_s2 == r_lvl) begin
            r_cnt <= '0;
         end else if (r_cnt == DEB_CYCLES - 20'd1) begin
            r_lvl <= r_s2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 20'd1;
         end
      end
   end

   assign o_level = r_lvl;

endmodule

module period_setter #(
   parameter logic [19:0] DEB_CYCLES   = 20'd500000,
   parameter logic [26:0] REPEAT_DELAY = 27'd25000000,
   parameter logic [26:0] REPEAT_RATE  = 27'd5000000,
   parameter logic [7:0]  MIN_PERIOD   = 8'd1,
   parameter logic [7:0]  MAX_PERIOD   = 8'd250,
   parameter logic [7:0]  INIT_PERIOD  = 8'd100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_dn,
   input  logic       btn_quick,
   output logic [7:0] period,
   output logic       quick,
   output logic       changed
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_REPEAT
   } state_t;

   logic        w_up_deb;
   logic        w_dn_deb;
   logic        w_qk_deb;

   logic        r_up_q;
   logic        r_dn_q;
   logic        r_qk_q;
   logic        r_up_ev;
   logic        r_dn_ev;
   logic        r_qk_ev;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [26:0] r_rcnt;
   logic [26:0] w_rcnt_nxt;
   logic        r_dir_up;
   logic        w_dir_nxt;
   logic        w_rep_step;
   logic        w_held;
   logic        w_both;

   logic        w_inc;
   logic        w_dec;
   logic [7:0]  r_period;
   logic [7:0]  w_period_nxt;
   logic        r_quick;
   logic        w_quick_nxt;
   logic        r_changed;

   ps_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (btn_up),
      .o_level (w_up_deb)
   );

   ps_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (btn_dn),
      .o_level (w_dn_deb)
   );

   ps_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_qk (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (btn_quick),
      .o_level (w_qk_deb)
   );

   // Delayed levels stay aligned with the registered press events
   always_ff @(posedge clk) begin
      if (rst) begin
         r_up_q  <= 1'b0;
         r_dn_q  <= 1'b0;
         r_qk_q  <= 1'b0;
         r_up_ev <= 1'b0;
         r_dn_ev <= 1'b0;
         r_qk_ev <= 1'b0;
      end else begin
         r_up_q  <= w_up_deb;
         r_dn_q  <= w_dn_deb;
         r_qk_q  <= w_qk_deb;
         r_up_ev <= w_up_deb & ~r_up_q;
         r_dn_ev <= w_dn_deb & ~r_dn_q;
         r_qk_ev <= w_qk_deb & ~r_qk_q;
      end
   end

   assign w_both = r_up_q & r_dn_q;
   assign w_held = r_dir_up ? r_up_q : r_dn_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_rcnt   <= '0;
         r_dir_up <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_rcnt   <= w_rcnt_nxt;
         r_dir_up <= w_dir_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rcnt_nxt  = r_rcnt;
      w_dir_nxt   = r_dir_up;
      w_rep_step  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_rcnt_nxt = '0;
            if (!w_both && (r_up_ev ^ r_dn_ev)) begin
               w_state_nxt = S_HOLD;
               w_dir_nxt   = r_up_ev;
            end
         end
         S_HOLD: begin
            if (!w_held || w_both) begin
               w_state_nxt = S_IDLE;
               w_rcnt_nxt  = '0;
            end else if (r_rcnt == REPEAT_DELAY - 27'd1) begin
               w_state_nxt = S_REPEAT;
               w_rcnt_nxt  = '0;
               w_rep_step  = 1'b1;
            end else begin
               w_rcnt_nxt = r_rcnt + 27'd1;
            end
         end
         S_REPEAT: begin
            if (!w_held || w_both) begin
               w_state_nxt = S_IDLE;
               w_rcnt_nxt  = '0;
            end else if (r_rcnt == REPEAT_RATE - 27'd1) begin
               w_rcnt_nxt = '0;
               w_rep_step = 1'b1;
            end else begin
               w_rcnt_nxt = r_rcnt + 27'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_rcnt_nxt  = '0;
         end
      endcase
   end

   assign w_inc = !w_both && (r_up_ev || (w_rep_step && r_dir_up));
   assign w_dec = !w_both && (r_dn_ev || (w_rep_step && !r_dir_up));

   // Limits are tested before the arithmetic so the value never wraps
   always_comb begin
      w_period_nxt = r_period;
      if (w_inc && (r_period < MAX_PERIOD)) begin
         w_period_nxt = r_period + 8'd1;
      end else if (w_dec && (r_period > MIN_PERIOD)) begin
         w_period_nxt = r_period - 8'd1;
      end
   end

   assign w_quick_nxt = r_quick ^ r_qk_ev;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_period  <= INIT_PERIOD;
         r_quick   <= 1'b0;
         r_changed <= 1'b0;
      end else begin
         r_period  <= w_period_nxt;
         r_quick   <= w_quick_nxt;
         r_changed <= (w_period_nxt != r_period) ||
                      (w_quick_nxt != r_quick);
      end
   end

   assign period  = r_period;
   assign quick   = r_quick;
   assign changed = r_changed;

endmodule

// File: tb/tb_period_setter.sv
// Randomized scoreboard bench for period_setter.
// A timing-level press model predicts each change pulse and its edge.

module tb_period_setter;

   localparam logic [19:0] DEB  = 20'd4;
   localparam logic [26:0] RDLY = 27'd20;
   localparam logic [26:0] RRAT = 27'd5;
   localparam logic [7:0]  PMIN = 8'd1;
   localparam logic [7:0]  PMAX = 8'd9;
   localparam logic [7:0]  PINI = 8'd5;
   localparam int          LAT  = 7;
   localparam int          GAP  = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bu  = 1'b0;
   logic       bd  = 1'b0;
   logic       bq  = 1'b0;
   logic [7:0] period;
   logic       quick;
   logic       changed;

   period_setter #(
      .DEB_CYCLES   (DEB),
      .REPEAT_DELAY (RDLY),
      .REPEAT_RATE  (RRAT),
      .MIN_PERIOD   (PMIN),
      .MAX_PERIOD   (PMAX),
      .INIT_PERIOD  (PINI)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_up    (bu),
      .btn_dn    (bd),
      .btn_quick (bq),
      .period    (period),
      .quick     (quick),
      .changed   (changed)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         t;
      logic [7:0] p;
      logic       q;
   } exp_t;

   exp_t       sb[$];
   exp_t       e_mon;
   int         passed = 0;
   int         total  = 0;
   int         pulses = 0;
   logic [7:0] m_p    = PINI;
   logic       m_q    = 1'b0;
   logic [7:0] last_p = PINI;
   logic       last_q = 1'b0;

   task automatic chk(string name, int act, int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                    name, act, req, cyc);
   endtask

   function automatic logic [7:0] stp(logic [7:0] p, bit up);
      if (up) return (p >= PMAX) ? p : p + 8'd1;
      return (p <= PMIN) ? p : p - 8'd1;
   endfunction

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Raw level first sampled at edge n, held h edges; release debounced
   // lets steps happen up to edge n+h+6.
   task automatic plan(bit up, bit dn, bit qk, int h);
      int         n  = cyc + 1;
      logic [7:0] np = m_p;
      logic       nq = qk ? ~m_q : m_q;
      if (up ^ dn) np = stp(m_p, up);
      if (np != m_p || nq != m_q) sb.push_back('{n + LAT, np, nq});
      m_p = np;
      m_q = nq;
      if (up ^ dn) begin
         for (int t = n + LAT + int'(RDLY); t <= n + h + 6;
              t += int'(RRAT)) begin
            np = stp(m_p, up);
            if (np != m_p) begin
               sb.push_back('{t, np, m_q});
               m_p = np;
            end
         end
      end
   endtask

   task automatic press(bit up, bit dn, bit qk, int h);
      plan(up, dn, qk, h);
      bu = up;
      bd = dn;
      bq = qk;
      tick(h);
      bu = 1'b0;
      bd = 1'b0;
      bq = 1'b0;
      tick(GAP);
   endtask

   task automatic do_reset(int n);
      rst = 1'b1;
      tick(n);
      sb.delete();
      m_p = PINI;
      m_q = 1'b0;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (changed) begin
            pulses++;
            if (sb.size() == 0) begin
               total++;
               $display("FAIL unexpected_change: period=%0d quick=%0d cycle %0d, none expected",
                        period, quick, cyc);
            end else begin
               e_mon = sb.pop_front();
               chk("step_cycle", cyc, e_mon.t);
               chk("step_period", int'(period), int'(e_mon.p));
               chk("step_quick", int'(quick), int'(e_mon.q));
            end
         end else begin
            if (period != last_p || quick != last_q) begin
               total++;
               $display("FAIL silent_change: period %0d->%0d quick %0d->%0d, changed=0",
                        last_p, period, last_q, quick);
            end
            while (sb.size() > 0 && sb[0].t < cyc) begin
               total++;
               $display("FAIL missed_step: got no pulse, expected period=%0d at cycle %0d",
                        sb[0].p, sb[0].t);
               void'(sb.pop_front());
            end
         end
      end
      last_p = period;
      last_q = quick;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int p0;
   int k;
   int h;

   initial begin
      tick(2);
      chk("reset_period", int'(period), int'(PINI));
      chk("reset_quick", int'(quick), 0);
      chk("reset_changed", int'(changed), 0);
      do_reset(1);

      for (int i = 0; i < 15; i++) begin
         bu = (i % 2 == 0);
         tick(2);
      end
      bu = 1'b0;
      tick(GAP);
      chk("bounce_period", int'(period), int'(PINI));
      chk("bounce_pulses", pulses, 0);

      press(1, 0, 0, 8);
      press(0, 1, 0, 8);
      chk("clean_back", int'(period), int'(PINI));

      p0 = pulses;
      for (int i = 0; i < 10; i++) press(1, 0, 0, 8);
      chk("sat_max", int'(period), int'(PMAX));
      chk("sat_max_pulses", pulses - p0, 4);
      p0 = pulses;
      for (int i = 0; i < 10; i++) press(0, 1, 0, 8);
      chk("sat_min", int'(period), int'(PMIN));
      chk("sat_min_pulses", pulses - p0, 8);

      press(1, 0, 0, 80);
      chk("rep_up", int'(period), int'(PMAX));
      p0 = pulses;
      press(0, 1, 0, 80);
      chk("rep_dn", int'(period), int'(PMIN));
      chk("rep_dn_pulses", pulses - p0, 8);

      press(1, 1, 0, 30);
      chk("both_hold", int'(period), int'(PMIN));
      p0 = pulses;
      press(1, 0, 1, 8);
      chk("quick_step_pulses", pulses - p0, 1);
      chk("quick_step_q", int'(quick), 1);

      plan(1, 0, 0, 200);
      bu = 1'b1;
      tick(35);
      bu = 1'b0;
      do_reset(2);
      tick(40);
      chk("midrep_period", int'(period), int'(PINI));
      chk("midrep_quick", int'(quick), 0);

      bu = 1'b1;
      do_reset(2);
      press(1, 0, 0, 8);
      chk("held_reset", int'(period), int'(PINI) + 1);

      for (int i = 0; i < 30; i++) begin
         k = $urandom_range(0, 4);
         h = $urandom_range(6, 60);
         case (k)
            0: press(1, 0, 0, h);
            1: press(0, 1, 0, h);
            2: press(0, 0, 1, h);
            3: press(1, 0, 1, h);
            default: press(1, 1, $urandom_range(0, 1), h);
         endcase
      end

      tick(20);
      chk("queue_empty", sb.size(), 0);
      chk("final_period", int'(period), int'(m_p));
      chk("final_quick", int'(quick), int'(m_q));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
